seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//  Programmable serial bit-sequence detector: a Mealy-style match flag for a runtime-loaded pattern of 1..MAX_LEN bits.
//  Supports overlapping and non-overlapping modes, a registered (Moore-timed) copy of the flag, and a saturating match counter.
//  Sits on a 1-bit serial data path; the output flags feed downstream control logic and the counter is readable by status logic.
//  Generalises the fixed 3-bit "101" detector. Reset configuration is "101", overlapping, so it is a drop-in replacement.
// PARAMETERS
//  MAX_LEN  8  maximum pattern length in bits (>=3)
//  LEN_W    4  width of pat_len; must hold MAX_LEN
//  CNT_W    8  width of match_cnt
// PORTS
//  clk        in   1        clock, all logic on posedge
//  rst        in   1        synchronous reset, active-high
//  x          in   1        serial data bit
//  in_valid   in   1        x is sampled only when 1; when 0, history, fill and flags hold
//  cfg_load   in   1        load pat/len/overlap; history flushed
//  cfg_pat    in   MAX_LEN  pattern; cfg_pat[len-1] is first bit in time, cfg_pat[0] last
//  cfg_len    in   LEN_W    pattern length
//  cfg_ovl    in   1        1 = overlapping, 0 = non-overlapping
//  cnt_clr    in   1        clear match_cnt
//  z          out  1        combinational match flag, same cycle as final bit (Mealy)
//  z_q        out  1        z registered: 1 cycle after the final bit
//  match_cnt  out  CNT_W    saturating count of matches
//  fill       out  LEN_W    number of valid history bits (0..MAX_LEN)
// BEHAVIOUR
//  Reset (rst=1 at posedge): pat=...0101, len=3, ovl=1, hist=0, fill=0, z_q=0, match_cnt=0. z=0 while rst=1.
//  Config: on a posedge with cfg_load=1, latch the cfg_* inputs, clear hist and fill, clear z_q. Do not sample x that cycle; z=0 that cycle.
//  Config clamping: cfg_len>MAX_LEN stores MAX_LEN. cfg_len=0 is stored as 0, and then no match ever occurs.
//  Window: w = {hist[MAX_LEN-2:0], x}, with the newest bit at LSB.
//  Match condition (combinational): in_valid & ~cfg_load & ~rst & len!=0 & (fill+1 >= len) & (w[len-1:0] == pat[len-1:0]).
//    Only the low len bits are compared.
//  z = match condition; there is no extra latency.
//  Update on a posedge with in_valid=1 and cfg_load=0:
//    hist <= w.
//    If z & ~ovl: fill <= 0 (history is discarded, so no bit of this match is reused).
//    Otherwise: fill <= min(fill+1, MAX_LEN).
//  z_q <= z on every posedge except reset or cfg_load, where it is 0. A pulse lasts exactly 1 cycle per match.
//  match_cnt: increments by 1 on each posedge where z=1. It holds at 2^CNT_W-1 (no wrap).
//  cnt_clr=1: match_cnt <= 0, and has priority over a simultaneous match. That match still asserts z and z_q.
//  Simultaneous cfg_load and in_valid: cfg_load wins and x is dropped.
//  Reset mid-sequence: partial progress is lost, and the next match needs len fresh bits.
//  Gaps: in_valid=0 cycles are transparent; 1,(gap),0,1 still matches "101".
// TESTING
//  1 Reset default, x stream 1,0,1,0,1 (in_valid=1) -> z high on bits 3 and 5 (overlap); z_q one cycle later; match_cnt=2.
//  2 Load pat=8'b0000_0110 len=3 ovl=0; stream 1,1,0,1,1,0,1,1,0 -> z on bits 3,6,9; match_cnt=3.
//  3 Load pat=8'b0000_0011 len=2, ovl=0 vs ovl=1; stream 1,1,1,1 -> ovl=0: matches at bits 2,4; ovl=1: matches at bits 2,3,4.
//  4 Default pattern; 1,0 then in_valid=0 for 3 cycles, then 1 -> z=1 on the final bit only; fill=3 afterwards.
//  5 CNT_W=2; 5 matches of "101" -> match_cnt 1,2,3,3,3. cnt_clr asserted with the 6th match -> match_cnt=0, z=1.
//  6 Stream 1,0 then rst=1 for 1 cycle, then 1 -> no match. Also cfg_load with cfg_len=12 -> len=8; cfg_len=0 -> z never asserts over 32 random bits.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector with a Mealy match flag, its registered
// copy, overlapping/non-overlapping modes and a saturating match counter.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               z,
    output logic               z_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(3'b101);
    localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(3);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               z_d;

    logic [MAX_LEN-1:0] w_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               fill_ok_s;

    // Match evaluation: compare only the low len bits of the window, gated by enough history.
    always_comb begin
        w_s    = {hist_q, x};
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_q));
        end
        fill_ok_s = (({1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q});
        z = in_valid & ~cfg_load & ~rst & (len_q != {LEN_W{1'b0}}) & fill_ok_s
            & (((w_s ^ pat_q) & mask_s) == {MAX_LEN{1'b0}});
    end

    // Next-state logic for configuration, history, fill and counter.
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        z_d    = z;
        if (cfg_load) begin
            pat_d  = cfg_pat;
            len_d  = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            ovl_d  = cfg_ovl;
            hist_d = {(MAX_LEN-1){1'b0}};
            fill_d = {LEN_W{1'b0}};
        end else if (in_valid) begin
            hist_d = w_s[MAX_LEN-2:0];
            // A non-overlapping match discards all history so no bit is reused.
            if (z && !ovl_q) begin
                fill_d = {LEN_W{1'b0}};
            end else if (fill_q == MAX_LEN_L) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
            end
        end else begin
            hist_d = hist_q;
        end
        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (z && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset to the "101" overlapping configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= RST_PAT;
            len_q  <= RST_LEN;
            ovl_q  <= 1'b1;
            hist_q <= {(MAX_LEN-1){1'b0}};
            fill_q <= {LEN_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            z_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
        end
    end

    assign match_cnt = cnt_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomised scoreboard bench for seq_detect_prog; two instances (8-bit and 2-bit counters)
// share stimulus and are checked against a queue-based reference model.
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       in_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pat = 8'd0;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_ovl = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       z, z_q, z2, z2_q;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [3:0] fill, fill2;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
        .z(z), .z_q(z_q), .match_cnt(cnt8), .fill(fill));

    seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
        .z(z2), .z_q(z2_q), .match_cnt(cnt2), .fill(fill2));

    typedef struct {
        bit z;
        bit zq;
        int c8;
        int c2;
        int fill;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: history as a list of valid bits, newest at the back.
    bit       mq[$];
    int       m_len = 3;
    bit [7:0] m_pat = 8'b0000_0101;
    bit       m_ovl = 1'b1;
    int       m_c8 = 0;
    int       m_c2 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit xb, input bit v, input bit ld,
                        input bit [7:0] p, input int ln, input bit o, input bit clr);
        exp_t e;
        bit   ez;
        bit   ok;
        bit   b;
        @(negedge clk);
        rst = r; x = xb; in_valid = v; cfg_load = ld;
        cfg_pat = p; cfg_len = 4'(ln); cfg_ovl = o; cnt_clr = clr;
        ez = 1'b0;
        if (!r && !ld && v && m_len != 0 && (mq.size() + 1) >= m_len) begin
            ok = 1'b1;
            for (int j = 0; j < m_len; j++) begin
                b = (j == 0) ? xb : mq[mq.size() - j];
                if (b != m_pat[j]) ok = 1'b0;
            end
            ez = ok;
        end
        if (r) begin
            mq.delete();
            m_len = 3; m_pat = 8'b0000_0101; m_ovl = 1'b1;
            m_c8 = 0; m_c2 = 0;
        end else begin
            if (clr) begin
                m_c8 = 0; m_c2 = 0;
            end else if (ez) begin
                m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
                m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
            end
            if (ld) begin
                mq.delete();
                m_len = (ln > 8) ? 8 : ln;
                m_pat = p; m_ovl = o;
            end else if (v) begin
                if (ez && !m_ovl) begin
                    mq.delete();
                end else begin
                    mq.push_back(xb);
                    if (mq.size() > 8) void'(mq.pop_front());
                end
            end
        end
        e.z = ez; e.zq = ez; e.c8 = m_c8; e.c2 = m_c2; e.fill = mq.size();
        sb.push_back(e);
    endtask

    task automatic bit_in(input bit xb);
        step(1'b0, xb, 1'b1, 1'b0, 8'd0, 0, 1'b0, 1'b0);
    endtask

    task automatic load(input bit [7:0] p, input int ln, input bit o);
        step(1'b0, 1'b0, 1'b1, 1'b1, p, ln, o, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0, 1'b0);
    endtask

    task automatic bits(input bit [15:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(s[i]);
    endtask

    // Monitor: combinational flag checked mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("z", int'(z), int'(e.z));
                chk("z_cnt2", int'(z2), int'(e.z));
                @(posedge clk);
                #1;
                chk("z_q", int'(z_q), int'(e.zq));
                chk("z_q_cnt2", int'(z2_q), int'(e.zq));
                chk("match_cnt8", int'(cnt8), e.c8);
                chk("match_cnt2", int'(cnt2), e.c2);
                chk("fill", int'(fill), e.fill);
                chk("fill_cnt2", int'(fill2), e.fill);
            end
        end
    end

    initial begin
        int drain;
        do_reset(); do_reset();
        // default "101" overlapping
        bits(16'b10101, 5);
        // "110" non-overlapping
        load(8'b0000_0110, 3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0, 1'b1);
        bits(16'b110110110, 9);
        // "11" non-overlapping then overlapping
        load(8'b0000_0011, 2, 1'b0);
        bits(16'b1111, 4);
        load(8'b0000_0011, 2, 1'b1);
        bits(16'b1111, 4);
        // gaps are transparent
        do_reset();
        bit_in(1'b1); bit_in(1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'b0, 1'b0, 8'd0, 0, 1'b0, 1'b0);
        bit_in(1'b1);
        // saturation of the 2-bit counter and clear priority
        do_reset();
        bits(16'b10101010101, 11);
        bit_in(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 0, 1'b0, 1'b1);
        // reset mid-sequence
        bit_in(1'b1); bit_in(1'b0);
        do_reset();
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        // length clamp to MAX_LEN, then zero length
        load(8'hA5, 12, 1'b1);
        bits(16'hA5A5, 16);
        load(8'h00, 0, 1'b1);
        for (int i = 0; i < 32; i++) bit_in(1'($urandom));
        // simultaneous load and valid bit
        load(8'b0000_0001, 1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0001, 1, 1'b1, 1'b0);
        bit_in(1'b1);
        // random phase
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 3) begin
                load(8'($urandom), int'($urandom_range(0, 5)), 1'($urandom));
            end else if (sel < 4) begin
                load(8'($urandom), int'($urandom_range(0, 12)), 1'($urandom));
            end else if (sel < 5) begin
                do_reset();
            end else begin
                step(1'b0, 1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 8'd0, 0, 1'b0,
                     ($urandom_range(0, 49) == 0));
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0, 1'b0);
        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        repeat (2) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
